// File: rtl/div_unit_pkg.sv
// rtl/div_unit_pkg.sv - shared op encodings, FSM states and constants for div_unit
`timescale 1ns/1ps
package div_unit_pkg;

    localparam int XLEN_DEF = 32;

    localparam logic [31:0] INT_MIN = 32'h8000_0000;

    typedef enum logic [1:0] {
        DIV_OP_DIV  = 2'b00,
        DIV_OP_DIVU = 2'b01,
        DIV_OP_REM  = 2'b10,
        DIV_OP_REMU = 2'b11
    } div_op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_CALC = 2'b01,
        ST_FIX  = 2'b10,
        ST_DONE = 2'b11
    } div_state_e;

endpackage

// File: rtl/div_unit_step.sv
// rtl/div_unit_step.sv - one combinational restoring-division iteration on magnitudes
`timescale 1ns/1ps
module div_step #(
    parameter int XLEN = 32
) (
    input  logic [XLEN:0]   rem_i,
    input  logic [XLEN-1:0] quo_i,
    input  logic [XLEN-1:0] divisor_i,
    output logic [XLEN:0]   rem_o,
    output logic [XLEN-1:0] quo_o
);

    logic [XLEN+1:0] rem_sh;
    logic [XLEN+1:0] diff;
    logic            borrow;

    assign rem_sh = {rem_i, quo_i[XLEN-1]};
    assign diff   = rem_sh - {2'b00, divisor_i};
    assign borrow = diff[XLEN+1];

    // On borrow the shifted remainder is restored; otherwise the difference is kept.
    assign rem_o = borrow ? rem_sh[XLEN:0] : diff[XLEN:0];
    assign quo_o = {quo_i[XLEN-2:0], ~borrow};

endmodule

// File: rtl/div_unit.sv
// rtl/div_unit.sv - multi-cycle radix-2 restoring divider (DIV/DIVU/REM/REMU)
// Optional quotient/remainder reuse entry enabled by DIV_QR_REUSE_EN.
`timescale 1ns/1ps
module div_unit
    import div_unit_pkg::*;
#(
    parameter int XLEN = XLEN_DEF
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic            flush,
    input  logic [1:0]      op,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result
);

    localparam int              CW      = $clog2(XLEN);
    localparam logic [XLEN-1:0] ONES    = '1;
    localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

    div_state_e      state_q, state_d;
    logic [CW-1:0]   cnt_q;
    logic [XLEN:0]   rem_q;
    logic [XLEN-1:0] quo_q;
    logic [XLEN-1:0] dvs_q;
    logic [XLEN-1:0] result_q;
    logic [1:0]      op_q;
    logic            a_neg_q, b_neg_q;

    logic [XLEN:0]   rem_step;
    logic [XLEN-1:0] quo_step;
    logic            accept, div0, ovf, hit, special;
    logic            a_neg, b_neg;
    logic [XLEN-1:0] a_abs, b_abs;
    logic [XLEN-1:0] special_res, quo_fix, rem_fix;

`ifdef DIV_QR_REUSE_EN
    logic            qr_valid_q;
    logic            qr_sgn_q;
    logic [XLEN-1:0] qr_a_q, qr_b_q, qr_quo_q, qr_rem_q;
    logic [XLEN-1:0] a_q, b_q;

    assign hit = qr_valid_q && (a == qr_a_q) && (b == qr_b_q) && (op[0] == qr_sgn_q);
`else
    assign hit = 1'b0;
`endif

    assign accept  = start && !flush && (state_q == ST_IDLE || state_q == ST_DONE);
    assign div0    = (b == '0);
    assign ovf     = !op[0] && (a == MIN_NEG) && (b == ONES);
    assign special = div0 || ovf || hit;

    assign a_neg = !op[0] && a[XLEN-1];
    assign b_neg = !op[0] && b[XLEN-1];
    assign a_abs = a_neg ? -a : a;
    assign b_abs = b_neg ? -b : b;

    assign quo_fix = (a_neg_q ^ b_neg_q) ? -quo_q : quo_q;
    assign rem_fix = a_neg_q ? -rem_q[XLEN-1:0] : rem_q[XLEN-1:0];

    always_comb begin
        special_res = '0;
        if (div0)
            special_res = op[1] ? a : ONES;
        else if (ovf)
            special_res = op[1] ? '0 : MIN_NEG;
`ifdef DIV_QR_REUSE_EN
        else if (hit)
            special_res = op[1] ? qr_rem_q : qr_quo_q;
`endif
    end

    div_step #(.XLEN(XLEN)) u_step (
        .rem_i     (rem_q),
        .quo_i     (quo_q),
        .divisor_i (dvs_q),
        .rem_o     (rem_step),
        .quo_o     (quo_step)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state_q <= ST_IDLE;
        else
            state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (flush) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE, ST_DONE: begin
                    if (start)
                        state_d = special ? ST_DONE : ST_CALC;
                    else
                        state_d = ST_IDLE;
                end
                ST_CALC: if (cnt_q == '0) state_d = ST_FIX;
                ST_FIX:  state_d = ST_DONE;
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_comb begin
        busy = 1'b0;
        done = 1'b0;
        case (state_q)
            ST_CALC, ST_FIX: busy = 1'b1;
            ST_DONE:         done = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q    <= '0;
            rem_q    <= '0;
            quo_q    <= '0;
            dvs_q    <= '0;
            result_q <= '0;
            op_q     <= '0;
            a_neg_q  <= 1'b0;
            b_neg_q  <= 1'b0;
`ifdef DIV_QR_REUSE_EN
            a_q        <= '0;
            b_q        <= '0;
            qr_valid_q <= 1'b0;
            qr_sgn_q   <= 1'b0;
            qr_a_q     <= '0;
            qr_b_q     <= '0;
            qr_quo_q   <= '0;
            qr_rem_q   <= '0;
`endif
        end else if (accept) begin
            op_q    <= op;
            a_neg_q <= a_neg;
            b_neg_q <= b_neg;
            quo_q   <= a_abs;
            dvs_q   <= b_abs;
            rem_q   <= '0;
            cnt_q   <= CW'(XLEN - 1);
`ifdef DIV_QR_REUSE_EN
            a_q <= a;
            b_q <= b;
`endif
            if (special)
                result_q <= special_res;
        end else if (!flush && state_q == ST_CALC) begin
            rem_q <= rem_step;
            quo_q <= quo_step;
            cnt_q <= cnt_q - CW'(1);
        end else if (!flush && state_q == ST_FIX) begin
            result_q <= op_q[1] ? rem_fix : quo_fix;
`ifdef DIV_QR_REUSE_EN
            // Keep both halves so a following DIV/REM pair on the same operands skips CALC.
            qr_valid_q <= 1'b1;
            qr_sgn_q   <= op_q[0];
            qr_a_q     <= a_q;
            qr_b_q     <= b_q;
            qr_quo_q   <= quo_fix;
            qr_rem_q   <= rem_fix;
`endif
        end
    end

    assign result = result_q;

endmodule

// File: tb/tb_div_unit.sv
// tb/tb_div_unit.sv - self-checking bench for div_unit (vector table, random ops, flush/reset sequences)
`timescale 1ns/1ps
module tb_div_unit;
    import div_unit_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        flush = 1'b0;
    logic [1:0]  op = 2'b00;
    logic [31:0] a = '0;
    logic [31:0] b = '0;
    logic        busy, done;
    logic [31:0] result;

    int n_cmp = 0;
    int n_fail = 0;

    localparam int LAT_NORM = 34;
`ifdef DIV_QR_REUSE_EN
    localparam int LAT_REUSE = 1;
    logic        m_valid = 1'b0;
    logic        m_sgn = 1'b0;
    logic [31:0] m_a = '0, m_b = '0;
`else
    localparam int LAT_REUSE = LAT_NORM;
`endif

    typedef struct {
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
        int          lat;
    } vec_t;

    vec_t vecs[13];

    div_unit #(.XLEN(32)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .flush  (flush),
        .op     (op),
        .a      (a),
        .b      (b),
        .busy   (busy),
        .done   (done),
        .result (result)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] ref_res(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
        int sx, sy;
        if (y == 0) return o[1] ? x : 32'hFFFF_FFFF;
        if (!o[0]) begin
            if (x == INT_MIN && y == 32'hFFFF_FFFF) return o[1] ? 32'h0 : INT_MIN;
            sx = x;
            sy = y;
            return o[1] ? 32'(sx % sy) : 32'(sx / sy);
        end
        return o[1] ? x % y : x / y;
    endfunction

    function automatic int exp_lat(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
        if (y == 0) return 1;
        if (!o[0] && x == INT_MIN && y == 32'hFFFF_FFFF) return 1;
`ifdef DIV_QR_REUSE_EN
        if (m_valid && m_a == x && m_b == y && m_sgn == o[0]) return 1;
`endif
        return LAT_NORM;
    endfunction

    // Call at a negedge; returns at the negedge where done is seen (or after a timeout, lat=-1).
    task automatic run_op(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y, input int poke,
                          output logic [31:0] res, output int lat, output logic busy_ok);
        int le;
        le = exp_lat(o, x, y);
        op = o; a = x; b = y; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        a = $urandom; b = $urandom; op = 2'($urandom);
        lat = 0;
        busy_ok = 1'b1;
        while (lat < 60) begin
            @(negedge clk);
            lat++;
            if (done) break;
            if (!busy) busy_ok = 1'b0;
            if (lat == poke) begin
                start = 1'b1; op = DIV_OP_DIV; a = 32'd5; b = 32'd0;
            end else if (lat == poke + 1) begin
                start = 1'b0;
            end
        end
        start = 1'b0;
        if (!done) lat = -1;
        if (busy) busy_ok = 1'b0;
        res = result;
`ifdef DIV_QR_REUSE_EN
        if (done && le == LAT_NORM) begin
            m_valid = 1'b1; m_a = x; m_b = y; m_sgn = o[0];
        end
`else
        le = le;
`endif
    endtask

    initial begin
        logic [31:0] res, exp_prev, x, y;
        logic [1:0]  o;
        logic        bok, saw_done;
        int          lat, le, r;

        vecs[0]  = '{DIV_OP_DIV,  32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD, LAT_NORM};
        vecs[1]  = '{DIV_OP_REM,  32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, LAT_REUSE};
        vecs[2]  = '{DIV_OP_DIVU, 32'hFFFF_FFFF, 32'h10,        32'h0FFF_FFFF, LAT_NORM};
        vecs[3]  = '{DIV_OP_REMU, 32'hFFFF_FFFF, 32'h10,        32'h0000_000F, LAT_REUSE};
        vecs[4]  = '{DIV_OP_DIV,  32'd123,       32'd0,         32'hFFFF_FFFF, 1};
        vecs[5]  = '{DIV_OP_REM,  32'd123,       32'd0,         32'd123,       1};
        vecs[6]  = '{DIV_OP_DIV,  32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1};
        vecs[7]  = '{DIV_OP_REM,  32'h8000_0000, 32'hFFFF_FFFF, 32'h0,         1};
        vecs[8]  = '{DIV_OP_DIV,  32'd100,       32'd7,         32'd14,        LAT_NORM};
        vecs[9]  = '{DIV_OP_REM,  32'd100,       32'd7,         32'd2,         LAT_REUSE};
        vecs[10] = '{DIV_OP_REMU, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, LAT_NORM};
        vecs[11] = '{DIV_OP_DIVU, 32'd0,         32'd0,         32'hFFFF_FFFF, 1};
        vecs[12] = '{DIV_OP_REM,  32'd7,         32'hFFFF_FFFE, 32'd1,         LAT_NORM};

        #12;
        check("reset_busy", {31'b0, busy}, 32'd0);
        check("reset_done", {31'b0, done}, 32'd0);
        check("reset_result", result, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("idle_done", {31'b0, done}, 32'd0);

        foreach (vecs[i]) begin
            run_op(vecs[i].op, vecs[i].a, vecs[i].b, 0, res, lat, bok);
            check($sformatf("vec%0d_result", i), res, vecs[i].res);
            check($sformatf("vec%0d_latency", i), 32'(lat), 32'(vecs[i].lat));
            check($sformatf("vec%0d_busy", i), {31'b0, bok}, 32'd1);
        end
        exp_prev = vecs[12].res;

        repeat (3) @(negedge clk);
        check("result_hold", result, exp_prev);
        check("hold_done_low", {31'b0, done}, 32'd0);

        le = exp_lat(DIV_OP_DIVU, 32'd1000, 32'd3);
        run_op(DIV_OP_DIVU, 32'd1000, 32'd3, 5, res, lat, bok);
        check("busy_start_result", res, 32'd333);
        check("busy_start_latency", 32'(lat), 32'(le));
        exp_prev = 32'd333;

        op = DIV_OP_DIVU; a = 32'hFFFF_FFFF; b = 32'd3; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (10) @(negedge clk);
        flush = 1'b1; start = 1'b1; op = DIV_OP_DIV; a = 32'd50; b = 32'd0;
        @(negedge clk);
        flush = 1'b0; start = 1'b0;
        check("flush_busy", {31'b0, busy}, 32'd0);
        check("flush_done", {31'b0, done}, 32'd0);
        check("flush_result", result, exp_prev);
        saw_done = 1'b0;
        repeat (40) begin
            @(negedge clk);
            if (done) saw_done = 1'b1;
        end
        check("flush_no_done", {31'b0, saw_done}, 32'd0);
        check("flush_result_kept", result, exp_prev);
        le = exp_lat(DIV_OP_DIV, 32'd50, 32'd5);
        run_op(DIV_OP_DIV, 32'd50, 32'd5, 0, res, lat, bok);
        check("after_flush_result", res, 32'd10);
        check("after_flush_latency", 32'(lat), 32'(le));

        for (int k = 0; k < 40; k++) begin
            r = $urandom_range(0, 9);
            o = 2'($urandom);
            x = $urandom;
            y = $urandom;
            if (r == 0) y = 32'd0;
            else if (r == 1) begin x = INT_MIN; y = 32'hFFFF_FFFF; end
            else if (r == 2) y = $urandom_range(1, 15);
            else if (r == 3) x = $urandom_range(0, 100);
            repeat ($urandom_range(0, 2)) @(negedge clk);
            le = exp_lat(o, x, y);
            run_op(o, x, y, 0, res, lat, bok);
            check($sformatf("rand%0d_result op=%0d a=%08h b=%08h", k, o, x, y), res, ref_res(o, x, y));
            check($sformatf("rand%0d_latency", k), 32'(lat), 32'(le));
        end

        op = DIV_OP_DIVU; a = 32'h1234_5678; b = 32'h11; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (5) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("midreset_done", {31'b0, done}, 32'd0);
        check("midreset_busy", {31'b0, busy}, 32'd0);
        check("midreset_result", result, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
`ifdef DIV_QR_REUSE_EN
        m_valid = 1'b0;
`endif
        @(negedge clk);
        check("postreset_done", {31'b0, done}, 32'd0);
        le = exp_lat(DIV_OP_REMU, 32'h1234_5678, 32'h11);
        run_op(DIV_OP_REMU, 32'h1234_5678, 32'h11, 0, res, lat, bok);
        check("postreset_result", res, 32'h1234_5678 % 32'h11);
        check("postreset_latency", 32'(lat), 32'(le));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
